rmt_tx_framer: RTL and testbench

//  Egress counterpart of the RMT ingress classifier: builds RMT frames from a descriptor plus a raw AXIS payload.

---
 rtl/rmt_pkg.sv | 56 +++++
 rtl/rmt_ipv4_csum.sv | 22 ++
 rtl/rmt_tx_framer.sv | 184 ++++++++++++++++++
 tb/tb_rmt_tx_framer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkg.sv
// RMT frame constants shared by the egress framer and the ingress classifier.
// Header layout, IPv4/UDP fixed fields, framer state encoding.
`timescale 1ns/1ps
package rmt_pkg;

  localparam int RMT_HDR_BYTES = 46;
  localparam int ETH_TYPE_OFF  = 12;
  localparam int DELIM_OFF     = 42;
  localparam int FUNC_OFF      = 44;

  localparam logic [15:0] RMT_DELIM      = 16'hF0E1;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TOS         = 8'h00;
  localparam logic [15:0] IP_ID          = 16'h0000;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam logic [7:0]  IP_TTL         = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] IP_FIXED_LEN   = 16'd32;
  localparam logic [15:0] UDP_FIXED_LEN  = 16'd12;
  localparam logic [15:0] UDP_CSUM       = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_HEAD,
    ST_BODY,
    ST_FLUSH
  } rmt_state_t;

  // Wire order is built MSB-first, then byte-reversed so byte i sits at [i*8+:8].
  function automatic logic [RMT_HDR_BYTES*8-1:0] rmt_hdr(
    input logic [47:0] dmac,
    input logic [47:0] smac,
    input logic [31:0] sip,
    input logic [31:0] dip,
    input logic [15:0] port,
    input logic [15:0] func,
    input logic [15:0] len,
    input logic [15:0] csum
  );
    logic [RMT_HDR_BYTES*8-1:0] w;
    logic [RMT_HDR_BYTES*8-1:0] h;
    w = {dmac, smac, ETHERTYPE_IPV4,
         IP_VER_IHL, IP_TOS, len + IP_FIXED_LEN,
         IP_ID, IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP,
         csum, sip, dip,
         port, port, len + UDP_FIXED_LEN, UDP_CSUM,
         RMT_DELIM[7:0], RMT_DELIM[15:8],
         func[7:0], func[15:8]};
    for (int i = 0; i < RMT_HDR_BYTES; i++)
      h[i*8+:8] = w[(RMT_HDR_BYTES-1-i)*8+:8];
    return h;
  endfunction

endpackage

// File: rtl/rmt_ipv4_csum.sv
// IPv4 header checksum: ones'-complement sum of ten 16-bit words.
// Purely combinational; the framer registers the result.
`timescale 1ns/1ps
module rmt_ipv4_csum (
  input  logic [159:0] words,
  output logic [15:0]  csum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++)
      sum = sum + 20'(words[i*16+:16]);
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    csum  = ~fold2;
  end

endmodule

// File: rtl/rmt_tx_framer.sv
// RMT egress framer: prepends Eth/IPv4/UDP/RMT header to an AXIS payload.
// Payload is realigned behind the header through a residue register.
`timescale 1ns/1ps
module rmt_tx_framer #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 1,
  parameter int HDR_BYTES  = 46
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [47:0]           cfg_dst_mac,
  input  logic [47:0]           cfg_src_mac,
  input  logic [31:0]           cfg_src_ip,
  input  logic [31:0]           cfg_dst_ip,
  input  logic [15:0]           cfg_udp_port,
  input  logic                  s_hdr_valid,
  output logic                  s_hdr_ready,
  input  logic [15:0]           s_hdr_func,
  input  logic [15:0]           s_hdr_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  len_err
);
  import rmt_pkg::*;

  localparam int K  = KEEP_WIDTH;
  localparam int R  = HDR_BYTES;
  localparam int P  = K - R;
  localparam int CW = $clog2(K + 1);

  rmt_state_t            state;
  logic [15:0]           d_func;
  logic [15:0]           d_len;
  logic [15:0]           ip_csum;
  logic [R*8-1:0]        residue;
  logic [CW-1:0]         flush_n;
  logic [15:0]           byte_cnt;
  logic [USER_WIDTH-1:0] user_acc;
  logic                  err_hold;

  logic [CW-1:0]         n_in;
  logic [15:0]           cnt_next;
  logic                  out_free;
  logic                  acc;
  logic                  last_fits;
  logic [K-1:0]          last_keep;
  logic [K-1:0]          flush_keep;
  logic [R*8-1:0]        hdr;
  logic [159:0]          csum_words;
  logic [15:0]           csum_calc;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = ((state == ST_HEAD) || (state == ST_BODY)) && out_free;
  assign acc           = s_axis_tvalid && s_axis_tready;

  always_comb begin
    n_in = '0;
    for (int i = 0; i < K; i++)
      n_in = n_in + CW'(s_axis_tkeep[i]);
  end

  assign cnt_next  = byte_cnt + 16'(n_in);
  assign last_fits = n_in <= CW'(P);

  always_comb begin
    last_keep  = '0;
    flush_keep = '0;
    for (int i = 0; i < K; i++) begin
      last_keep[i]  = i < (R + int'(n_in));
      flush_keep[i] = i < int'(flush_n);
    end
  end

  assign csum_words = {{IP_VER_IHL, IP_TOS}, d_len + IP_FIXED_LEN,
                       IP_ID, IP_FLAGS_DF, {IP_TTL, IP_PROTO_UDP},
                       16'h0000, cfg_src_ip, cfg_dst_ip};

  rmt_ipv4_csum u_csum (
    .words (csum_words),
    .csum  (csum_calc)
  );

  assign hdr = rmt_hdr(cfg_dst_mac, cfg_src_mac, cfg_src_ip, cfg_dst_ip,
                       cfg_udp_port, d_func, d_len, ip_csum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      s_hdr_ready   <= 1'b0;
      d_func        <= '0;
      d_len         <= '0;
      ip_csum       <= '0;
      residue       <= '0;
      flush_n       <= '0;
      byte_cnt      <= '0;
      user_acc      <= '0;
      err_hold      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      len_err       <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (m_axis_tready)
        m_axis_tvalid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (s_hdr_valid && s_hdr_ready) begin
            d_func      <= s_hdr_func;
            d_len       <= s_hdr_len;
            s_hdr_ready <= 1'b0;
            state       <= ST_CALC;
          end else begin
            s_hdr_ready <= 1'b1;
          end
        end
        ST_CALC: begin
          ip_csum  <= csum_calc;
          byte_cnt <= '0;
          user_acc <= '0;
          err_hold <= 1'b0;
          state    <= ST_HEAD;
        end
        ST_HEAD, ST_BODY: begin
          if (acc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= (state == ST_HEAD)
                           ? {s_axis_tdata[P*8-1:0], hdr}
                           : {s_axis_tdata[P*8-1:0], residue};
            m_axis_tkeep  <= '1;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            residue       <= s_axis_tdata[K*8-1 -: R*8];
            byte_cnt      <= cnt_next;
            user_acc      <= user_acc | s_axis_tuser;
            state         <= ST_BODY;
            if (s_axis_tlast) begin
              if (last_fits) begin
                m_axis_tkeep <= last_keep;
                m_axis_tlast <= 1'b1;
                m_axis_tuser <= user_acc | s_axis_tuser;
                len_err      <= cnt_next != d_len;
                s_hdr_ready  <= 1'b1;
                state        <= ST_IDLE;
              end else begin
                // Tail spills past this beat: drain it from the residue.
                flush_n  <= n_in - CW'(P);
                err_hold <= cnt_next != d_len;
                state    <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {{(P*8){1'b0}}, residue};
            m_axis_tkeep  <= flush_keep;
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= user_acc;
            len_err       <= err_hold;
            s_hdr_ready   <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmt_tx_framer.sv
// Directed bench for rmt_tx_framer: golden byte streams, header fields,
// keep/last/user shaping, length error, async reset, ingress acceptance.
`timescale 1ns/1ps
module tb_rmt_tx_framer;

  localparam int DW = 512;
  localparam int KW = DW/8;
  localparam logic [47:0] DMAC = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SMAC = 48'h02_66_77_88_99_AA;
  localparam logic [31:0] SIP  = 32'hC0A8_0001;
  localparam logic [31:0] DIP  = 32'hC0A8_0002;
  localparam logic [15:0] PORT = 16'h1234;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_hdr_valid;
  logic          s_hdr_ready;
  logic [15:0]   s_hdr_func;
  logic [15:0]   s_hdr_len;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [0:0]    s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [0:0]    m_axis_tuser;
  logic          len_err;

  int tests = 0;
  int fails = 0;
  logic rand_ready = 1'b0;

  logic [7:0]    got_q[$];
  logic [7:0]    exp_q[$];
  int            beats;
  int            frames_done;
  int            err_pulses;
  int            err_misalign;
  int            user_mid;
  int            keep_bad;
  logic [KW-1:0] last_keep_seen;
  logic [0:0]    last_user;
  logic [DW-1:0] first_beat;

  rmt_tx_framer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .HDR_BYTES(46)) dut (
    .clk(clk), .rst(rst),
    .cfg_dst_mac(DMAC), .cfg_src_mac(SMAC),
    .cfg_src_ip(SIP), .cfg_dst_ip(DIP), .cfg_udp_port(PORT),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_hdr_func(s_hdr_func), .s_hdr_len(s_hdr_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // Sink monitor: samples mid-cycle, handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      beats++;
      if (beats == 1) first_beat = m_axis_tdata;
      for (int i = 0; i < KW; i++)
        if (m_axis_tkeep[i]) got_q.push_back(m_axis_tdata[i*8+:8]);
      last_keep_seen = m_axis_tkeep;
      if (m_axis_tlast) begin
        frames_done++;
        last_user = m_axis_tuser;
      end else begin
        if (m_axis_tuser != 1'b0) user_mid++;
        if (m_axis_tkeep != '1) keep_bad++;
      end
    end
    if (!rst && len_err) begin
      err_pulses++;
      if (!(m_axis_tvalid && m_axis_tlast)) err_misalign++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [7:0] pay(input int idx, input int seed);
    return 8'(idx * 7 + seed * 13 + 1);
  endfunction

  function automatic void push16(input logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endfunction

  function automatic void build_exp(input logic [15:0] f, input logic [15:0] dl,
                                    input int n, input int seed);
    logic [31:0] s;
    logic [15:0] cs;
    logic [15:0] tot;
    tot = dl + 16'd32;
    s = 32'h4500 + 32'(tot) + 32'h4000 + 32'h4011
      + 32'(SIP[31:16]) + 32'(SIP[15:0]) + 32'(DIP[31:16]) + 32'(DIP[15:0]);
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cs = ~s[15:0];
    exp_q.delete();
    for (int i = 5; i >= 0; i--) exp_q.push_back(DMAC[i*8+:8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(SMAC[i*8+:8]);
    push16(16'h0800);
    push16(16'h4500);
    push16(tot);
    push16(16'h0000);
    push16(16'h4000);
    push16(16'h4011);
    push16(cs);
    push16(SIP[31:16]); push16(SIP[15:0]);
    push16(DIP[31:16]); push16(DIP[15:0]);
    push16(PORT); push16(PORT);
    push16(dl + 16'd12);
    push16(16'h0000);
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'hF0);
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    for (int i = 0; i < n; i++) exp_q.push_back(pay(i, seed));
  endfunction

  function automatic int byte_mism();
    int m;
    m = (got_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic logic [15:0] hdr_csum_sum();
    logic [31:0] s;
    s = 0;
    if (got_q.size() < 34) return 16'h0;
    for (int i = 0; i < 10; i++) s = s + {16'h0, got_q[14+2*i], got_q[15+2*i]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  // Reference view of the ingress filter: accept RMT frames, tdest from func.
  function automatic int classify();
    if (got_q.size() < 46) return -1;
    if ({got_q[12], got_q[13]} != 16'h0800) return -1;
    if (got_q[23] != 8'd17) return -1;
    if ({got_q[36], got_q[37]} != PORT) return -1;
    if (got_q[42] != 8'hE1 || got_q[43] != 8'hF0) return -1;
    return ({got_q[45], got_q[44]} == 16'h0001) ? 1 : 0;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    beats = 0; frames_done = 0; err_pulses = 0; err_misalign = 0;
    user_mid = 0; keep_bad = 0; last_keep_seen = '0; last_user = '0;
    first_beat = '0;
  endtask

  task automatic wait_accept(input logic is_hdr);
    int t;
    t = 0;
    @(negedge clk);
    while (!(is_hdr ? s_hdr_ready : s_axis_tready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check(is_hdr ? "hdr_accept_timeout" : "beat_accept_timeout", 64'(t), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [15:0] f, input logic [15:0] dl);
    s_hdr_func = f;
    s_hdr_len = dl;
    s_hdr_valid = 1'b1;
    wait_accept(1'b1);
    s_hdr_valid = 1'b0;
  endtask

  task automatic drive_beat(input int n, input int b, input int seed, input int ubeat);
    int rem;
    int cnt;
    int nb;
    nb = (n + KW - 1) / KW;
    rem = n - b * KW;
    cnt = (rem > KW) ? KW : rem;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    for (int i = 0; i < cnt; i++) begin
      s_axis_tdata[i*8+:8] = pay(b * KW + i, seed);
      s_axis_tkeep[i] = 1'b1;
    end
    s_axis_tlast = (b == nb - 1);
    s_axis_tuser = 1'(b == ubeat);
    s_axis_tvalid = 1'b1;
    wait_accept(1'b0);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(frames_done), 64'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] f, input logic [15:0] dl,
                           input int n, input int seed, input int ubeat);
    clear_mon();
    build_exp(f, dl, n, seed);
    send_desc(f, dl);
    for (int b = 0; b < (n + KW - 1) / KW; b++) drive_beat(n, b, seed, ubeat);
    wait_frames({tag, "_done"}, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_hdr_valid = 1'b0; s_hdr_func = '0; s_hdr_len = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = '0; m_axis_tready = 1'b1;
    clear_mon();
    #2;
    check("rst_m_tvalid", 64'(m_axis_tvalid), 0);
    check("rst_hdr_ready", 64'(s_hdr_ready), 0);
    check("rst_s_tready", 64'(s_axis_tready), 0);
    check("rst_len_err", 64'(len_err), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    s_axis_tvalid = 1'b1;
    s_axis_tkeep = '1;
    repeat (3) @(negedge clk);
    check("pre_desc_backpressure", 64'(s_axis_tready), 0);
    check("idle_hdr_ready", 64'(s_hdr_ready), 1);
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;

    run_frame("len10", 16'h0001, 16'd10, 10, 1, -1);
    check("len10_beats", 64'(beats), 1);
    check("len10_keep", 64'(last_keep_seen), 64'h00FF_FFFF_FFFF_FFFF);
    check("len10_ethertype", 64'(first_beat[12*8+:16]), 64'h0008);
    check("len10_delim", 64'(first_beat[42*8+:16]), 64'hF0E1);
    check("len10_func", 64'(first_beat[44*8+:16]), 64'h0001);
    check("len10_ip_csum", 64'(hdr_csum_sum()), 64'hFFFF);
    check("len10_bytes", 64'(byte_mism()), 0);
    check("len10_tdest", 64'(classify()), 1);
    check("len10_len_err", 64'(err_pulses), 0);

    run_frame("len18", 16'h0001, 16'd18, 18, 2, -1);
    check("len18_beats", 64'(beats), 1);
    check("len18_keep", 64'(last_keep_seen), 64'hFFFF_FFFF_FFFF_FFFF);
    check("len18_bytes", 64'(byte_mism()), 0);

    run_frame("len19", 16'h0001, 16'd19, 19, 3, -1);
    check("len19_beats", 64'(beats), 2);
    check("len19_keep", 64'(last_keep_seen), 64'h1);
    check("len19_bytes", 64'(byte_mism()), 0);
    check("len19_len_err", 64'(err_pulses), 0);

    rand_ready = 1'b1;
    run_frame("len200", 16'h0001, 16'd200, 200, 4, 1);
    rand_ready = 1'b0;
    check("len200_beats", 64'(beats), 4);
    check("len200_keep", 64'(last_keep_seen), 64'h003F_FFFF_FFFF_FFFF);
    check("len200_bytes", 64'(byte_mism()), 0);
    check("len200_tuser_last", 64'(last_user), 1);
    check("len200_tuser_mid", 64'(user_mid), 0);
    check("len200_keep_mid", 64'(keep_bad), 0);
    check("len200_ip_csum", 64'(hdr_csum_sum()), 64'hFFFF);

    run_frame("lenerr", 16'h0001, 16'd100, 64, 5, -1);
    check("lenerr_beats", 64'(beats), 2);
    check("lenerr_keep", 64'(last_keep_seen), 64'h0000_3FFF_FFFF_FFFF);
    check("lenerr_bytes", 64'(byte_mism()), 0);
    check("lenerr_pulses", 64'(err_pulses), 1);
    check("lenerr_align", 64'(err_misalign), 0);

    run_frame("func2", 16'h0002, 16'd30, 30, 6, -1);
    check("func2_tdest", 64'(classify()), 0);
    check("func2_bytes", 64'(byte_mism()), 0);

    clear_mon();
    send_desc(16'h0001, 16'd200);
    drive_beat(200, 0, 7, -1);
    drive_beat(200, 1, 7, -1);
    #2 rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 64'(m_axis_tvalid), 0);
    check("midrst_m_tdata", 64'(|m_axis_tdata), 0);
    check("midrst_m_tlast", 64'(m_axis_tlast), 0);
    check("midrst_s_tready", 64'(s_axis_tready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame("postrst", 16'h0001, 16'd19, 19, 8, -1);
    check("postrst_beats", 64'(beats), 2);
    check("postrst_bytes", 64'(byte_mism()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
